button_conditioner: RTL and testbench

Parametrised N-channel push-button front end for the signed-multiplier board UI. It synchronises raw pad inputs and samples them on a shared divided tick. Each channel is debounced with symmetric hysteresis. The block emits clean levels plus single-`clk`-cycle press/release pulses, with optional auto-repeat while a button is held. It replaces per-button divider/debounce/edge chains, and all outputs are in the `clk` domain.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 55 +++++
 tb/tb_button_conditioner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM state type and counter sizing helpers for button_conditioner
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    // Bits needed to hold 0..n-1, never less than one so n=1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button lane: 2-FF sync, hysteretic debounce, press/release FSM
// Auto-repeat counter and REPEAT state are built only when BUTTON_REPEAT_EN is defined.
module button_channel
    import button_pkg::*;
#(
    parameter int DEB_SAMPLES  = 3,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int DW = cnt_width(DEB_SAMPLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_SAMPLES - 1);

    logic          sync_0;
    logic          sync_1;
    logic [DW-1:0] dcnt;
    logic          flip;
    btn_state_t    state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= btn_raw;
            sync_1 <= sync_0;
        end
    end

    // flip marks the tick on which the debounced level changes; the FSM keys its pulses off it.
    assign flip = tick && (sync_1 != level) && (dcnt == DEB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt  <= '0;
            level <= 1'b0;
        end else if (tick) begin
            if (sync_1 == level) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                level <= sync_1;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            rcnt          <= '0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (flip && !sync_1) begin
                state         <= ST_IDLE;
                release_pulse <= 1'b1;
                rcnt          <= '0;
            end else if (flip && sync_1) begin
                state <= ST_HELD;
                press <= 1'b1;
                rcnt  <= '0;
            end else if (tick) begin
                case (state)
                    ST_HELD: begin
                        if (rcnt == RD_LAST) begin
                            press <= 1'b1;
                            state <= ST_REPEAT;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt == RR_LAST) begin
                            press <= 1'b1;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    default: rcnt <= '0;
                endcase
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY + REPEAT_RATE) > 0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (flip && !sync_1) begin
                state         <= ST_IDLE;
                release_pulse <= 1'b1;
            end else if (flip && sync_1) begin
                state <= ST_HELD;
                press <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N-channel button front end: shared sample tick plus per-channel lanes
// Auto-repeat on held buttons is enabled by defining BUTTON_REPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 30000,
    parameter int DEB_SAMPLES  = 3,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press,
    // "release" is a reserved word, hence the suffix.
    output logic [N_CH-1:0] release_pulse,
    output logic            tick
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tcnt == TICK_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign tick = (tcnt == TICK_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEB_SAMPLES (DEB_SAMPLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .btn_raw      (btn_in[i]),
            .level        (level_out[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scenario and randomized bench for button_conditioner
module tb_button_conditioner;
    import button_pkg::*;

    localparam int N_CH = 4;
    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int RD   = 5;
    localparam int RR   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn_in = '0;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;
    logic            tick;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_CH(N_CH), .TICK_DIV(TD), .DEB_SAMPLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .level_out(level_out),
        .press(press), .release_pulse(release_pulse), .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset, input history, and per-channel run lengths of disagreeing samples.
    int              ecnt;
    int              tick_idx;
    int              run [N_CH];
    int              press_tick [N_CH];
    logic [N_CH-1:0] d1, d2, m_level, m_press, m_rel;
    logic            m_tick;

    task automatic model_reset();
        ecnt = 0; tick_idx = 0;
        d1 = '0; d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
        m_tick = (TD == 1);
        for (int i = 0; i < N_CH; i++) begin
            run[i] = 0;
            press_tick[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [N_CH-1:0] b);
        bit t;
        int n;
        t = ((ecnt % TD) == TD - 1);
        ecnt++;
        m_press = '0;
        m_rel   = '0;
        if (t) begin
            tick_idx++;
            for (int c = 0; c < N_CH; c++) begin
                if (d2[c] != m_level[c]) run[c]++;
                else run[c] = 0;
                if (run[c] == DEB) begin
                    run[c] = 0;
                    m_level[c] = d2[c];
                    if (d2[c]) begin
                        m_press[c] = 1'b1;
                        press_tick[c] = tick_idx;
                    end else begin
                        m_rel[c] = 1'b1;
                    end
                end else if (m_level[c]) begin
                    n = tick_idx - press_tick[c];
`ifdef BUTTON_REPEAT_EN
                    if (n >= RD && ((n - RD) % RR) == 0) m_press[c] = 1'b1;
`else
                    if (n < 0) m_press[c] = 1'b0;
`endif
                end
            end
        end
        d2 = d1;
        d1 = b;
        m_tick = ((ecnt % TD) == TD - 1);
    endtask

    task automatic cycle(input logic [N_CH-1:0] b);
        btn_in = b;
        @(posedge clk);
        if (!rst) model_edge(b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({level_out, press, release_pulse, tick} !== '0) begin
            errors++;
            $display("FAIL reset_state obs=%h exp=0", {level_out, press, release_pulse, tick});
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle('0);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL idle_after_reset obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int rel_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'b0001);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL clean_press obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
            if (press[0] && first < 0) begin
                first = i + 1;
                checks++;
                if (level_out[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL press_level_coincide obs=%b exp=1", level_out[0]);
                end
            end
        end
        checks++;
        if (first < 1 || first > 2 + DEB * TD) begin
            errors++;
            $display("FAIL press_latency obs=%0d exp<=%0d", first, 2 + DEB * TD);
        end
        for (int i = 0; i < 30; i++) begin
            cycle('0);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL clean_release obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
            if (release_pulse[0]) rel_cnt++;
        end
        checks++;
        if (rel_cnt != 1) begin
            errors++;
            $display("FAIL release_count obs=%0d exp=1", rel_cnt);
        end
    endtask

    task automatic test_bounce();
        int bounce_press = 0;
        int hold_press = 0;
        // Phase the toggle so every tick samples 0, the case where toggling must stay invisible.
        for (int i = 0; i < 20; i++) begin
            cycle({2'b00, (ecnt % 2 == 0), 1'b0});
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL bounce_toggle obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
            if (press[1] || release_pulse[1]) bounce_press++;
        end
        for (int i = 0; i < 16; i++) begin
            cycle(4'b0010);
            if (press[1]) hold_press++;
        end
        checks++;
        if (bounce_press != 0 || hold_press != 1) begin
            errors++;
            $display("FAIL bounce_press_count obs=%0d/%0d exp=0/1", bounce_press, hold_press);
        end
        for (int i = 0; i < 20; i++) cycle('0);
    endtask

    task automatic test_short_pulse();
        int activity = 0;
        for (int i = 0; i < 27; i++) begin
            cycle((i < 7) ? 4'b0100 : 4'b0000);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL short_pulse obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
            if (level_out[2] || press[2] || release_pulse[2]) activity++;
        end
        checks++;
        if (activity != 0) begin
            errors++;
            $display("FAIL short_pulse_silent obs=%0d exp=0", activity);
        end
    endtask

    task automatic test_simultaneous();
        int both = 0;
        int other = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(4'b1001);
            checks++;
            if (press[0] !== press[3]) begin
                errors++;
                $display("FAIL simultaneous_align obs=%b%b exp=equal", press[3], press[0]);
            end
            if (press[0] && press[3]) both++;
            if (press[1] || press[2] || level_out[1] || level_out[2]) other++;
        end
        checks++;
        if (both < 1 || other != 0) begin
            errors++;
            $display("FAIL simultaneous_pulses obs=%0d/%0d exp=>=1/0", both, other);
        end
        for (int i = 0; i < 20; i++) cycle('0);
    endtask

    task automatic test_reset_mid();
        int first = -1;
        for (int i = 0; i < 10; i++) cycle(4'b0001);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({level_out, press, release_pulse, tick} !== '0) begin
            errors++;
            $display("FAIL async_reset obs=%h exp=0", {level_out, press, release_pulse, tick});
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(4'b0001);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cycle(4'b0001);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL reset_redebounce obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
            if (press[0] && first < 0) first = i + 1;
        end
        checks++;
        if (first != DEB * TD) begin
            errors++;
            $display("FAIL reset_press_latency obs=%0d exp=%0d", first, DEB * TD);
        end
        for (int i = 0; i < 20; i++) cycle('0);
    endtask

    task automatic test_repeat();
        int cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(4'b0010);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL repeat_hold obs=%h exp=%h", {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
            if (press[1]) cnt++;
        end
        checks++;
`ifdef BUTTON_REPEAT_EN
        if (cnt < 5) begin
            errors++;
            $display("FAIL repeat_count obs=%0d exp>=5", cnt);
        end
`else
        if (cnt != 1) begin
            errors++;
            $display("FAIL repeat_count obs=%0d exp=1", cnt);
        end
`endif
        for (int i = 0; i < 20; i++) cycle('0);
    endtask

    task automatic test_random();
        logic [N_CH-1:0] cur = '0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 19) == 0) cur[c] = ~cur[c];
            cycle(cur);
            checks++;
            if ({level_out, press, release_pulse, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL random cyc=%0d obs=%h exp=%h", i, {level_out, press, release_pulse, tick}, {m_level, m_press, m_rel, m_tick});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_pulse();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
